hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Second-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
//  - Resolves E- and D-stage forwarding, load-use stalls and branch-in-D stalls.
//  - Adds a multi-cycle multiply/divide (MDU) busy scoreboard, taken-branch D flush,
//    a stall watchdog and a saturating stall-cycle counter.
//  Instantiated beside the datapath; drives stall/flush enables of the pipeline registers.
// PARAMETERS
//  RA_W        5     register-address width (2**RA_W architectural registers)
//  MDU_LAT     4     MDU latency in cycles from Mdu_Start_E to HI/LO valid (>=1)
//  STALL_LIMIT 64    consecutive Stall_D cycles that set Stall_Timeout (>=1)
//  CNT_W       16    width of Stall_Count
// PORTS
//  clk            in   1      pipeline clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  Rs_D,Rt_D      in   RA_W   source registers of the D-stage instruction
//  Rs_E,Rt_E      in   RA_W   source registers of the E-stage instruction
//  Write_Reg_E/M/W in  RA_W   destination register in E/M/W
//  Reg_Write_E/M/W in  1      destination write enable in E/M/W
//  Mem_To_Reg_E/M in   1      E/M instruction is a load
//  Branch_D       in   1      D-stage instruction is a branch (compared in D)
//  Pc_Src_D       in   1      D-stage branch taken
//  Mdu_Start_E    in   1      E-stage instruction issues mult/div this cycle
//  Mdu_Use_D      in   1      D-stage instruction reads HI/LO or issues mult/div
//  Forward_AE/BE  out  2      E operand mux: 00 regfile, 01 W result, 10 M ALU result
//  Forward_AD/BD  out  1      D comparator operand taken from M ALU result
//  Stall_F,Stall_D out 1      hold PC / hold IF-ID register
//  Flush_E        out  1      insert bubble into ID-EX register
//  Flush_D        out  1      clear IF-ID register (taken branch)
//  Mdu_Busy       out  1      MDU result pending
//  Stall_Timeout  out  1      sticky: stall exceeded STALL_LIMIT
//  Mdu_Overlap    out  1      sticky: Mdu_Start_E while Mdu_Busy
//  Stall_Count    out  CNT_W  saturating count of cycles with Stall_D=1
// BEHAVIOUR
//  Register 0 never matches (no forward, no stall) in any comparison below.
//  Forward_AE: 10 if Rs_E==Write_Reg_M&&Reg_Write_M; else 01 if ==Write_Reg_W&&Reg_Write_W;
//    else 00. Forward_BE identical on Rt_E. M has priority over W.
//  Forward_AD = Rs_D==Write_Reg_M && Reg_Write_M && !Mem_To_Reg_M; Forward_BD same on Rt_D.
//  Lw_Stall  = Mem_To_Reg_E && Rt_E!=0 && (Rt_E==Rs_D || Rt_E==Rt_D).
//  Br_Stall  = Branch_D && ((Reg_Write_E && Write_Reg_E in {Rs_D,Rt_D}) ||
//              (Mem_To_Reg_M && Reg_Write_M && Write_Reg_M in {Rs_D,Rt_D})).
//  Mdu_Stall = Mdu_Use_D && Mdu_Busy.
//  Stall_F = Stall_D = Flush_E = Lw_Stall | Br_Stall | Mdu_Stall (combinational, same cycle).
//  Flush_D = Pc_Src_D && !Stall_D (taken branch never flushes while held).
//  MDU scoreboard: counter mdu_cnt (clog2(MDU_LAT+1) bits).
//    Edge with Mdu_Start_E: mdu_cnt <= MDU_LAT (reload even if busy; then set Mdu_Overlap).
//    Else if mdu_cnt!=0: mdu_cnt <= mdu_cnt-1. Mdu_Busy = (mdu_cnt!=0), registered-derived.
//    Start at edge t -> Mdu_Busy high cycles t+1..t+MDU_LAT, low at t+MDU_LAT+1.
//  Watchdog: run_cnt counts consecutive Stall_D cycles, clears on any cycle Stall_D=0;
//    when run_cnt reaches STALL_LIMIT set Stall_Timeout (sticky until reset). run_cnt saturates.
//  Stall_Count increments each edge with Stall_D=1, saturates at 2**CNT_W-1, never wraps.
//  Reset (rst_n low, async): mdu_cnt, run_cnt, Stall_Count, Stall_Timeout, Mdu_Overlap = 0;
//    hence Mdu_Busy=0, Mdu_Stall=0. Combinational outputs follow inputs during reset.
//    Reset mid-MDU-operation abandons the count; no Mdu_Busy after release.
//  Simultaneous Lw_Stall and Pc_Src_D: stall wins, Flush_D=0.
// TESTING
//  1 add $3 in M, add $3 in W, Rs_E=3 -> Forward_AE=10; drop Reg_Write_M -> 01; Rs_E=0 -> 00.
//  2 Load to Rt_E=5, Rs_D=5 -> Stall_F=Stall_D=Flush_E=1 one cycle; Stall_Count 0->1.
//  3 Branch_D, Write_Reg_E=7 Reg_Write_E, Rt_D=7 -> stall; next cycle Write_Reg_M=7 ALU -> Forward_BD=1, no stall.
//  4 MDU_LAT=4: Mdu_Start_E at edge 10, Mdu_Use_D held -> Stall_D high cycles 11-14, low at 15.
//  5 STALL_LIMIT=3, force Lw_Stall 3 cycles -> Stall_Timeout=1, stays 1 after stall clears; Mdu_Start_E twice
//    2 cycles apart -> Mdu_Overlap=1; rst_n pulse mid-count -> all sticky/counters 0, Mdu_Busy=0.
//  6 CNT_W=4, 20 stall cycles -> Stall_Count=15; Pc_Src_D with no stall -> Flush_D=1, with Lw_Stall -> 0.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// Hazard control for the 5-stage MIPS pipeline: E/D forwarding, load-use, branch and
// MDU-busy stalls, taken-branch flush, stall watchdog and saturating stall counter.
module hazard_scoreboard_unit #(
  parameter int RA_W        = 5,
  parameter int MDU_LAT     = 4,
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RA_W-1:0]   Rs_D,
  input  logic [RA_W-1:0]   Rt_D,
  input  logic [RA_W-1:0]   Rs_E,
  input  logic [RA_W-1:0]   Rt_E,
  input  logic [RA_W-1:0]   Write_Reg_E,
  input  logic [RA_W-1:0]   Write_Reg_M,
  input  logic [RA_W-1:0]   Write_Reg_W,
  input  logic              Reg_Write_E,
  input  logic              Reg_Write_M,
  input  logic              Reg_Write_W,
  input  logic              Mem_To_Reg_E,
  input  logic              Mem_To_Reg_M,
  input  logic              Branch_D,
  input  logic              Pc_Src_D,
  input  logic              Mdu_Start_E,
  input  logic              Mdu_Use_D,
  output logic [1:0]        Forward_AE,
  output logic [1:0]        Forward_BE,
  output logic              Forward_AD,
  output logic              Forward_BD,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Flush_E,
  output logic              Flush_D,
  output logic              Mdu_Busy,
  output logic              Stall_Timeout,
  output logic              Mdu_Overlap,
  output logic [CNT_W-1:0]  Stall_Count
);

  localparam int MW = $clog2(MDU_LAT + 1);
  localparam int RW = $clog2(STALL_LIMIT + 1);
  localparam logic [MW-1:0]    MDU_LOAD = MW'(MDU_LAT);
  localparam logic [RW-1:0]    RUN_MAX  = RW'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic [RW-1:0]    run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;
  logic             overlap_q, overlap_d;
  logic             lw_stall_s, br_stall_s, mdu_stall_s, stall_s;

  // Register 0 is hardwired zero, so it never creates a dependency.
  function automatic logic hit(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return (a == b) && (a != {RA_W{1'b0}});
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                         input logic [RA_W-1:0] wm, input logic rwm,
                                         input logic [RA_W-1:0] ww, input logic rww);
    if (rwm && hit(src, wm))      return 2'b10;
    else if (rww && hit(src, ww)) return 2'b01;
    else                          return 2'b00;
  endfunction

  assign Mdu_Busy      = (mdu_cnt_q != {MW{1'b0}});
  assign Stall_Timeout = timeout_q;
  assign Mdu_Overlap   = overlap_q;
  assign Stall_Count   = stall_cnt_q;

  always_comb begin
    Forward_AE  = fwd_sel(Rs_E, Write_Reg_M, Reg_Write_M, Write_Reg_W, Reg_Write_W);
    Forward_BE  = fwd_sel(Rt_E, Write_Reg_M, Reg_Write_M, Write_Reg_W, Reg_Write_W);
    Forward_AD  = Reg_Write_M && !Mem_To_Reg_M && hit(Rs_D, Write_Reg_M);
    Forward_BD  = Reg_Write_M && !Mem_To_Reg_M && hit(Rt_D, Write_Reg_M);
    lw_stall_s  = Mem_To_Reg_E && (hit(Rt_E, Rs_D) || hit(Rt_E, Rt_D));
    br_stall_s  = Branch_D &&
                  ((Reg_Write_E && (hit(Write_Reg_E, Rs_D) || hit(Write_Reg_E, Rt_D))) ||
                   (Mem_To_Reg_M && Reg_Write_M &&
                    (hit(Write_Reg_M, Rs_D) || hit(Write_Reg_M, Rt_D))));
    mdu_stall_s = Mdu_Use_D && Mdu_Busy;
    stall_s     = lw_stall_s || br_stall_s || mdu_stall_s;
    Stall_F     = stall_s;
    Stall_D     = stall_s;
    Flush_E     = stall_s;
    Flush_D     = Pc_Src_D && !stall_s;
  end

  // A new MDU issue reloads the countdown even when one is already in flight.
  always_comb begin
    mdu_cnt_d   = mdu_cnt_q;
    overlap_d   = overlap_q;
    run_cnt_d   = {RW{1'b0}};
    stall_cnt_d = stall_cnt_q;
    if (Mdu_Start_E) begin
      mdu_cnt_d = MDU_LOAD;
      overlap_d = overlap_q || Mdu_Busy;
    end else if (Mdu_Busy) begin
      mdu_cnt_d = mdu_cnt_q - {{(MW-1){1'b0}}, 1'b1};
    end else begin
      mdu_cnt_d = mdu_cnt_q;
    end
    if (stall_s) begin
      run_cnt_d   = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + {{(RW-1){1'b0}}, 1'b1};
      stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q
                                             : stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      run_cnt_d   = {RW{1'b0}};
      stall_cnt_d = stall_cnt_q;
    end
    timeout_d = timeout_q || (run_cnt_d == RUN_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt_q   <= {MW{1'b0}};
      run_cnt_q   <= {RW{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      timeout_q   <= 1'b0;
      overlap_q   <= 1'b0;
    end else begin
      mdu_cnt_q   <= mdu_cnt_d;
      run_cnt_q   <= run_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
      overlap_q   <= overlap_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed + randomized bench for hazard_scoreboard_unit against a behavioural model.
module tb_hazard_scoreboard_unit;
  localparam int RA_W = 5, MDU_LAT = 4, STALL_LIMIT = 3, CNT_W = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [RA_W-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic rw_e, rw_m, rw_w, mtr_e, mtr_m, branch_d, pc_src_d, mdu_start_e, mdu_use_d;
  logic [1:0] fwd_ae, fwd_be;
  logic fwd_ad, fwd_bd, stall_f, stall_d, flush_e, flush_d, mdu_busy, stall_to, mdu_ov;
  logic [CNT_W-1:0] stall_count;

  int checks = 0, failures = 0;
  int m_rem = 0, m_run = 0, m_cnt = 0;
  bit m_to = 1'b0, m_ov = 1'b0;

  hazard_scoreboard_unit #(.RA_W(RA_W), .MDU_LAT(MDU_LAT), .STALL_LIMIT(STALL_LIMIT),
                           .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Rs_D(rs_d), .Rt_D(rt_d), .Rs_E(rs_e), .Rt_E(rt_e),
    .Write_Reg_E(wr_e), .Write_Reg_M(wr_m), .Write_Reg_W(wr_w),
    .Reg_Write_E(rw_e), .Reg_Write_M(rw_m), .Reg_Write_W(rw_w),
    .Mem_To_Reg_E(mtr_e), .Mem_To_Reg_M(mtr_m), .Branch_D(branch_d), .Pc_Src_D(pc_src_d),
    .Mdu_Start_E(mdu_start_e), .Mdu_Use_D(mdu_use_d),
    .Forward_AE(fwd_ae), .Forward_BE(fwd_be), .Forward_AD(fwd_ad), .Forward_BD(fwd_bd),
    .Stall_F(stall_f), .Stall_D(stall_d), .Flush_E(flush_e), .Flush_D(flush_d),
    .Mdu_Busy(mdu_busy), .Stall_Timeout(stall_to), .Mdu_Overlap(mdu_ov),
    .Stall_Count(stall_count));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A dependency exists only on a real (nonzero) register.
  function automatic bit dep(input int a, input int b);
    return (a != 0) && (a == b);
  endfunction

  function automatic int exp_fwd_e(input int src);
    if (rw_m && dep(src, wr_m)) return 2;
    if (rw_w && dep(src, wr_w)) return 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit lw, br, md;
    lw = mtr_e && (dep(rt_e, rs_d) || dep(rt_e, rt_d));
    br = branch_d && ((rw_e && (dep(wr_e, rs_d) || dep(wr_e, rt_d))) ||
                      (mtr_m && rw_m && (dep(wr_m, rs_d) || dep(wr_m, rt_d))));
    md = mdu_use_d && (m_rem > 0);
    return lw || br || md;
  endfunction

  task automatic idle();
    {rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w} = '0;
    {rw_e, rw_m, rw_w, mtr_e, mtr_m, branch_d, pc_src_d, mdu_start_e, mdu_use_d} = '0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_busy"}, 32'(mdu_busy), 32'(m_rem > 0));
    check({tag, "_to"},   32'(stall_to), 32'(m_to));
    check({tag, "_ov"},   32'(mdu_ov),   32'(m_ov));
    check({tag, "_cnt"},  32'(stall_count), 32'(m_cnt));
  endtask

  // Inputs are already applied; check combinational outputs, advance model and clock.
  task automatic cycle(input string tag);
    bit st;
    #1;
    st = exp_stall();
    check({tag, "_fae"}, 32'(fwd_ae), 32'(exp_fwd_e(rs_e)));
    check({tag, "_fbe"}, 32'(fwd_be), 32'(exp_fwd_e(rt_e)));
    check({tag, "_fad"}, 32'(fwd_ad), 32'(rw_m && !mtr_m && dep(rs_d, wr_m)));
    check({tag, "_fbd"}, 32'(fwd_bd), 32'(rw_m && !mtr_m && dep(rt_d, wr_m)));
    check({tag, "_stl"}, 32'({stall_f, stall_d, flush_e}), 32'({st, st, st}));
    check({tag, "_fld"}, 32'(flush_d), 32'(pc_src_d && !st));
    if (mdu_start_e) begin
      if (m_rem > 0) m_ov = 1'b1;
      m_rem = MDU_LAT;
    end else if (m_rem > 0) m_rem--;
    if (st) begin
      if (m_run < STALL_LIMIT) m_run++;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else m_run = 0;
    if (m_run >= STALL_LIMIT) m_to = 1'b1;
    @(posedge clk); #1;
    check_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; #2;
    m_rem = 0; m_run = 0; m_cnt = 0; m_to = 1'b0; m_ov = 1'b0;
    check_regs(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    do_reset("rst0");
    // Forwarding priority M over W, and register 0 never forwards.
    wr_m = 5'd3; rw_m = 1'b1; wr_w = 5'd3; rw_w = 1'b1; rs_e = 5'd3; #1;
    check("t1_m", 32'(fwd_ae), 32'd2); cycle("t1a");
    rw_m = 1'b0; #1; check("t1_w", 32'(fwd_ae), 32'd1); cycle("t1b");
    rs_e = 5'd0; #1; check("t1_z", 32'(fwd_ae), 32'd0); cycle("t1c");
    // Load-use stall.
    idle(); mtr_e = 1'b1; rt_e = 5'd5; rs_d = 5'd5; #1;
    check("t2_st", 32'(stall_d), 32'd1); cycle("t2");
    check("t2_cnt1", 32'(stall_count), 32'd1);
    idle(); cycle("t2i");
    // Branch in D against E producer, then forwarded from M.
    branch_d = 1'b1; wr_e = 5'd7; rw_e = 1'b1; rt_d = 5'd7; cycle("t3a");
    rw_e = 1'b0; wr_m = 5'd7; rw_m = 1'b1; #1;
    check("t3_bd", 32'(fwd_bd), 32'd1); check("t3_ns", 32'(stall_d), 32'd0); cycle("t3b");
    // MDU busy window.
    idle(); mdu_start_e = 1'b1; cycle("t4s");
    mdu_start_e = 1'b0; mdu_use_d = 1'b1;
    for (int i = 0; i < MDU_LAT + 1; i++) cycle("t4u");
    check("t4_free", 32'(mdu_busy), 32'd0);
    // Watchdog and overlap stickiness, then reset mid-count.
    idle(); do_reset("t5r");
    mtr_e = 1'b1; rt_e = 5'd9; rs_d = 5'd9;
    cycle("t5a"); cycle("t5b"); check("t5_pre", 32'(stall_to), 32'd0);
    cycle("t5c"); check("t5_to", 32'(stall_to), 32'd1);
    idle(); cycle("t5d"); check("t5_stk", 32'(stall_to), 32'd1);
    mdu_start_e = 1'b1; cycle("t5e"); mdu_start_e = 1'b0; cycle("t5f");
    mdu_start_e = 1'b1; cycle("t5g"); mdu_start_e = 1'b0;
    check("t5_ov", 32'(mdu_ov), 32'd1);
    do_reset("t5rr"); cycle("t5h"); check("t5_nb", 32'(mdu_busy), 32'd0);
    // Stall counter saturation and taken-branch flush.
    mtr_e = 1'b1; rt_e = 5'd4; rt_d = 5'd4;
    for (int i = 0; i < 20; i++) cycle("t6s");
    check("t6_sat", 32'(stall_count), 32'd15);
    idle(); pc_src_d = 1'b1; #1; check("t6_fl", 32'(flush_d), 32'd1); cycle("t6f");
    mtr_e = 1'b1; rt_e = 5'd4; rs_d = 5'd4; #1;
    check("t6_nfl", 32'(flush_d), 32'd0); cycle("t6g");
    // Randomized traffic over a small register set to provoke dependencies.
    idle(); do_reset("rnd_r");
    for (int i = 0; i < 400; i++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      wr_e = 5'($urandom_range(0, 3)); wr_m = 5'($urandom_range(0, 3));
      wr_w = 5'($urandom_range(0, 3));
      rw_e = 1'($urandom); rw_m = 1'($urandom); rw_w = 1'($urandom);
      mtr_e = ($urandom_range(0, 3) == 0); mtr_m = ($urandom_range(0, 3) == 0);
      branch_d = ($urandom_range(0, 3) == 0); pc_src_d = 1'($urandom);
      mdu_start_e = ($urandom_range(0, 7) == 0); mdu_use_d = 1'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      cycle("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
